// File: rtl/steering_ctrl.sv
// Line-follower steering controller: popcount steering decode, debounced
// decisions, lost-line search with timeout, and halt.
module steering_ctrl #(
   parameter int N_SENSORS    = 5,
   parameter int DEBOUNCE     = 3,
   parameter int SEARCH_LIMIT = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [N_SENSORS-1:0] sensors,
   output logic                 left,
   output logic                 right,
   output logic                 walk,
   output logic                 searching,
   output logic                 halted
);
   localparam int C  = (N_SENSORS - 1) / 2;
   localparam int PW = $clog2(N_SENSORS + 1);
   localparam int DW = $clog2(DEBOUNCE + 1);
   localparam int SW = $clog2(SEARCH_LIMIT + 1);
   localparam logic [DW-1:0] DEB_MAX    = DW'(DEBOUNCE);
   localparam logic [SW-1:0] SEARCH_MAX = SW'(SEARCH_LIMIT);

   typedef enum logic [1:0] {D_NONE, D_FWD, D_LEFT, D_RIGHT} dec_t;
   typedef enum logic [2:0] {S_IDLE, S_FWD, S_LEFT, S_RIGHT, S_SEARCH, S_HALT} state_t;

   logic [PW-1:0] n_l, n_r;
   dec_t          raw, cand_reg, cand_next;
   logic [DW-1:0] cnt_reg, cnt_next;
   logic          stable;
   state_t        state_reg, state_next;
   logic [SW-1:0] scnt_reg, scnt_next, scnt_inc;
   logic          last_left_reg, last_left_next;

   function automatic state_t target(input dec_t d);
      case (d)
         D_FWD:   return S_FWD;
         D_LEFT:  return S_LEFT;
         D_RIGHT: return S_RIGHT;
         default: return S_SEARCH;
      endcase
   endfunction

   // The centre sensor never votes; it only keeps the decision off NONE.
   always_comb begin
      n_l = '0;
      n_r = '0;
      for (int i = 0; i < N_SENSORS; i++) begin
         if (i < C)
            n_r = n_r + PW'(sensors[i]);
         else if (i > C)
            n_l = n_l + PW'(sensors[i]);
      end
      if (sensors == '0)
         raw = D_NONE;
      else if (n_l > n_r)
         raw = D_LEFT;
      else if (n_r > n_l)
         raw = D_RIGHT;
      else
         raw = D_FWD;
   end

   always_comb begin
      if (raw == cand_reg) begin
         cand_next = cand_reg;
         cnt_next  = (cnt_reg == DEB_MAX) ? cnt_reg : cnt_reg + DW'(1);
      end else begin
         cand_next = raw;
         cnt_next  = DW'(1);
      end
      stable = (cnt_next == DEB_MAX);
   end

   always_comb begin
      state_next = state_reg;
      scnt_next  = '0;
      scnt_inc   = (scnt_reg == SEARCH_MAX) ? scnt_reg : scnt_reg + SW'(1);
      if (!enable) begin
         state_next = S_IDLE;
      end else begin
         case (state_reg)
            S_IDLE, S_FWD, S_LEFT, S_RIGHT: begin
               if (stable)
                  state_next = target(cand_next);
            end
            S_SEARCH: begin
               if (stable && cand_next != D_NONE)
                  state_next = target(cand_next);
               else if (scnt_inc == SEARCH_MAX)
                  state_next = S_HALT;
               else
                  scnt_next = scnt_inc;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
         endcase
      end
      last_left_next = last_left_reg;
      if (state_next == S_LEFT)
         last_left_next = 1'b1;
      else if (state_next == S_RIGHT)
         last_left_next = 1'b0;
   end

   // Outputs are registered from the next state so they track the state register exactly.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= S_IDLE;
         cand_reg      <= D_NONE;
         cnt_reg       <= '0;
         scnt_reg      <= '0;
         last_left_reg <= 1'b1;
         left          <= 1'b0;
         right         <= 1'b0;
         walk          <= 1'b0;
         searching     <= 1'b0;
         halted        <= 1'b0;
      end else begin
         state_reg     <= state_next;
         scnt_reg      <= scnt_next;
         last_left_reg <= last_left_next;
         if (!enable) begin
            cand_reg <= D_NONE;
            cnt_reg  <= '0;
         end else begin
            cand_reg <= cand_next;
            cnt_reg  <= cnt_next;
         end
         left      <= (state_next == S_LEFT) || (state_next == S_SEARCH && last_left_next);
         right     <= (state_next == S_RIGHT) || (state_next == S_SEARCH && !last_left_next);
         walk      <= (state_next == S_FWD) || (state_next == S_LEFT) || (state_next == S_RIGHT);
         searching <= (state_next == S_SEARCH);
         halted    <= (state_next == S_HALT);
      end
   end
endmodule

// File: tb/tb_steering_ctrl.sv
// Scoreboard bench for steering_ctrl: directed scenarios plus random sensor
// streams, checked against a history-based reference model.
module tb_steering_ctrl;
   localparam int N     = 5;
   localparam int D     = 3;
   localparam int LIMIT = 16;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         enable = 1'b0;
   logic [N-1:0] sensors = '0;
   logic         left, right, walk, searching, halted;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [4:0] outs;
      string      tag;
   } exp_t;
   exp_t exp_q[$];

   string m_state = "IDLE";
   string hist[$];
   int    m_scnt = 0;
   bit    m_last_left = 1'b1;

   steering_ctrl #(.N_SENSORS(N), .DEBOUNCE(D), .SEARCH_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset), .enable(enable), .sensors(sensors),
      .left(left), .right(right), .walk(walk), .searching(searching), .halted(halted)
   );

   always #5 clk = ~clk;

   function automatic string decide(input logic [N-1:0] s);
      int nl;
      int nr;
      nl = 0;
      nr = 0;
      if (s == '0) return "NONE";
      for (int i = 0; i < N; i++) begin
         if (s[i] && i > (N - 1) / 2) nl++;
         if (s[i] && i < (N - 1) / 2) nr++;
      end
      if (nl > nr) return "LEFT";
      if (nr > nl) return "RIGHT";
      return "FWD";
   endfunction

   // Expected outputs after the coming edge, given the inputs applied to it.
   task automatic model_edge(input bit rst, input bit en, input logic [N-1:0] s, input string tag);
      exp_t  e;
      string d;
      bit    stable;
      if (rst) begin
         m_state = "IDLE";
         hist.delete();
         m_scnt = 0;
         m_last_left = 1'b1;
      end else if (!en) begin
         m_state = "IDLE";
         hist.delete();
         m_scnt = 0;
      end else begin
         d = decide(s);
         hist.push_back(d);
         if (hist.size() > D) void'(hist.pop_front());
         stable = (hist.size() == D);
         foreach (hist[i]) if (hist[i] != d) stable = 1'b0;
         if (m_state == "SEARCH") begin
            if (stable && d != "NONE") begin
               m_state = d;
               m_scnt = 0;
            end else begin
               m_scnt++;
               if (m_scnt >= LIMIT) m_state = "HALT";
            end
         end else if (m_state != "HALT" && stable) begin
            if (d == "NONE") begin
               m_state = "SEARCH";
               m_scnt = 0;
            end else begin
               m_state = d;
            end
         end
         if (m_state == "LEFT") m_last_left = 1'b1;
         if (m_state == "RIGHT") m_last_left = 1'b0;
      end
      e.outs = {m_state == "LEFT" || (m_state == "SEARCH" && m_last_left),
                m_state == "RIGHT" || (m_state == "SEARCH" && !m_last_left),
                m_state == "FWD" || m_state == "LEFT" || m_state == "RIGHT",
                m_state == "SEARCH",
                m_state == "HALT"};
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic drive(input bit rst, input bit en, input logic [N-1:0] s, input string tag);
      @(posedge clk);
      #2;
      reset = rst;
      enable = en;
      sensors = s;
      model_edge(rst, en, s, tag);
   endtask

   task automatic hold(input bit rst, input bit en, input logic [N-1:0] s, input int n, input string tag);
      $display("txn %-14s reset=%0b enable=%0b sensors=%05b cycles=%0d", tag, rst, en, s, n);
      for (int k = 0; k < n; k++) drive(rst, en, s, tag);
   endtask

   // Monitor: every edge produces an output word; compare it with the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if ({left, right, walk, searching, halted} !== e.outs) begin
               bad++;
               $display("FAIL %s: lrwsh got=%05b want=%05b", e.tag,
                        {left, right, walk, searching, halted}, e.outs);
            end
            total++;
            if (left && right) begin
               bad++;
               $display("FAIL %s_excl: left=%0b right=%0b want not both 1", e.tag, left, right);
            end
         end
      end
   end

   initial begin
      logic [N-1:0] v;
      int n;
      hold(1, 0, 5'b00000, 2, "reset");
      hold(0, 1, 5'b00100, 4, "t1_fwd");
      hold(0, 1, 5'b11000, 2, "t2_glitch");
      hold(0, 1, 5'b00100, 3, "t2_back");
      hold(0, 1, 5'b11000, 4, "t2_left");
      for (int i = 0; i < 32; i++) begin
         v = N'(i);
         hold(0, 1, v, 4, $sformatf("t3_%05b", v));
      end
      hold(0, 1, 5'b00011, 4, "t4_right");
      hold(0, 1, 5'b00000, 4, "t4_lost");
      hold(0, 1, 5'b00100, 4, "t4_found");
      hold(0, 1, 5'b00000, 22, "t5_search");
      hold(0, 1, 5'b00100, 4, "t5_halt_hold");
      hold(0, 0, 5'b00100, 2, "t5_disable");
      hold(0, 1, 5'b00100, 4, "t5_refwd");
      hold(0, 1, 5'b00011, 4, "t6_right");
      hold(0, 1, 5'b00000, 5, "t6_search_r");
      hold(1, 1, 5'b00000, 1, "t6_reset");
      hold(0, 1, 5'b00000, 6, "t6_search_l");
      for (int t = 0; t < 400; t++) begin
         n = $urandom_range(0, 99);
         if (n < 3)
            hold(1, 1, N'($urandom_range(0, 31)), 1, "rnd_reset");
         else if (n < 8)
            hold(0, 0, N'($urandom_range(0, 31)), $urandom_range(1, 2), "rnd_disable");
         else if (n < 28)
            hold(0, 1, 5'b00000, $urandom_range(1, 22), "rnd_lost");
         else
            hold(0, 1, N'($urandom_range(0, 31)), $urandom_range(1, 5), "rnd_sens");
      end
      repeat (2) @(posedge clk);
      #3;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: pending=%0d want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
